// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared drain FSM encodings and FIFO sizing helper
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_GUARD = 2'd2,
    ST_WAIT  = 2'd3
  } tx_state_e;

  localparam int DATA_W_DEF     = 8;
  localparam int DEPTH_LOG2_DEF = 4;

  function automatic int fifo_depth(input int depth_log2);
    return 1 << depth_log2;
  endfunction

endpackage

// File: rtl/iob_uart_fifo_mem.sv
// rtl/iob_uart_fifo_mem.sv - sync-write / async-read register array for UART FIFOs
module iob_uart_fifo_mem
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = DEPTH_LOG2_DEF
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = fifo_depth(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - CPU-side TX FIFO draining one byte per core tx_ready window
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  rst_soft_i,
  input  logic                  tx_en_i,
  input  logic                  wr_en_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic                  clr_ovf_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  ovf_o,
  input  logic                  core_tx_ready_i,
  output logic                  core_wr_en_o,
  output logic [DATA_W-1:0]     core_tx_data_o
);

  localparam int LEVEL_W = DEPTH_LOG2 + 1;
  localparam int DEPTH   = fifo_depth(DEPTH_LOG2);
  localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(DEPTH);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0]    level_q, level_d;
  logic                  ovf_q, ovf_d;
  tx_state_e             state_q;
  logic                  core_wr_en_q;
  logic [DATA_W-1:0]     core_tx_data_q;
  logic [DATA_W-1:0]     rd_data;
  logic                  full, empty, push, pop;

  assign full  = (level_q == LEVEL_FULL);
  assign empty = (level_q == '0);
  assign push  = wr_en_i && !full;
  assign pop   = (state_q == ST_IDLE) && tx_en_i && !empty && core_tx_ready_i;

  iob_uart_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push && !rst_soft_i),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LEVEL_W'(1);
      2'b01:   level_d = level_q - LEVEL_W'(1);
      default: level_d = level_q;
    endcase
    // A dropped push wins over a same-cycle clear so no overflow goes unreported.
    if (wr_en_i && full) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (rst_soft_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // GUARD ignores tx_ready while the core is still dropping it after our write.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q        <= ST_IDLE;
      core_wr_en_q   <= 1'b0;
      core_tx_data_q <= '0;
    end else if (rst_soft_i) begin
      state_q        <= ST_IDLE;
      core_wr_en_q   <= 1'b0;
      core_tx_data_q <= '0;
    end else begin
      core_wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            state_q        <= ST_LOAD;
            core_wr_en_q   <= 1'b1;
            core_tx_data_q <= rd_data;
          end
        end
        ST_LOAD:  state_q <= ST_GUARD;
        ST_GUARD: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (core_tx_ready_i) begin
            state_q <= ST_IDLE;
          end
        end
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign full_o         = full;
  assign empty_o        = empty;
  assign level_o        = level_q;
  assign ovf_o          = ovf_q;
  assign core_wr_en_o   = core_wr_en_q;
  assign core_tx_data_o = core_tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo drain ordering and flags
module tb_uart_tx_fifo;

  localparam int DATA_W     = 8;
  localparam int DEPTH_LOG2 = 4;

  logic                clk = 1'b0;
  logic                arst = 1'b1;
  logic                rst_soft = 1'b0;
  logic                tx_en = 1'b0;
  logic                wr_en = 1'b0;
  logic [DATA_W-1:0]   wr_data = '0;
  logic                clr_ovf = 1'b0;
  logic                core_ready = 1'b1;
  logic                full, empty, ovf, core_wr_en;
  logic [DEPTH_LOG2:0] level;
  logic [DATA_W-1:0]   core_data;

  uart_tx_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clk_i           (clk),
    .arst_i          (arst),
    .rst_soft_i      (rst_soft),
    .tx_en_i         (tx_en),
    .wr_en_i         (wr_en),
    .wr_data_i       (wr_data),
    .clr_ovf_i       (clr_ovf),
    .full_o          (full),
    .empty_o         (empty),
    .level_o         (level),
    .ovf_o           (ovf),
    .core_tx_ready_i (core_ready),
    .core_wr_en_o    (core_wr_en),
    .core_tx_data_o  (core_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] exp_q[$];
  int pulses = 0;
  bit lat_armed = 1'b0;
  int lat_exp = 0;
  bit gap_chk = 1'b0;
  bit have_last = 1'b0;
  int last_pulse = 0;
  int busy_len = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] b, input bit keep);
    wr_data = b;
    wr_en = 1'b1;
    if (keep) exp_q.push_back(b);
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      step();
      i++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Monitor: every write pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (!arst && core_wr_en) begin
      pulses++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_pulse: got data %0d expected no pulse", core_data);
      end else begin
        chk("drain_data", int'(core_data), int'(exp_q.pop_front()));
      end
      if (lat_armed) begin
        chk("latency_cycle", cyc, lat_exp);
        lat_armed = 1'b0;
      end
      if (gap_chk) begin
        if (have_last) chk("pulse_gap_ge_50", int'((cyc - last_pulse) >= 50), 1);
        have_last = 1'b1;
        last_pulse = cyc;
      end
    end
  end

  // Core model: optionally drops tx_ready for busy_len cycles after each write.
  initial begin
    forever begin
      @(negedge clk);
      if (core_wr_en && busy_len > 0) begin
        core_ready = 1'b0;
        repeat (busy_len) @(negedge clk);
        core_ready = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int p;
    repeat (3) step();
    arst = 1'b0;
    step();
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_wr_en", int'(core_wr_en), 0);
    chk("rst_data", int'(core_data), 0);

    tx_en = 1'b1;
    repeat (100) step();
    chk("idle_pulses", pulses, 0);

    lat_armed = 1'b1;
    lat_exp = cyc + 2;
    push(8'h41, 1'b1);
    wait_drain(20, "b41");
    repeat (4) step();
    chk("b41_level", int'(level), 0);
    chk("b41_empty", int'(empty), 1);

    tx_en = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    chk("fill_full", int'(full), 1);
    chk("fill_level", int'(level), 16);
    chk("fill_ovf_clear", int'(ovf), 0);
    push(8'hFF, 1'b0);
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_level", int'(level), 16);
    clr_ovf = 1'b1;
    push(8'hFE, 1'b0);
    clr_ovf = 1'b0;
    chk("ovf_set_beats_clr", int'(ovf), 1);
    tx_en = 1'b1;
    wait_drain(200, "fill16");
    repeat (4) step();
    chk("fill16_level", int'(level), 0);

    busy_len = 50;
    gap_chk = 1'b1;
    have_last = 1'b0;
    for (int i = 0; i < 3; i++) push(8'hA1 + 8'(i), 1'b1);
    wait_drain(400, "busy");
    repeat (60) step();
    gap_chk = 1'b0;
    busy_len = 0;
    chk("pulse_total", pulses, 20);

    tx_en = 1'b0;
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), 1'b1);
    chk("pp_level_pre", int'(level), 5);
    for (int k = 0; k < 12; k++) begin
      wr_data = 8'h50 + 8'(k);
      wr_en = 1'b1;
      tx_en = 1'b1;
      exp_q.push_back(wr_data);
      step();
      wr_en = 1'b0;
      chk("pp_level_hold", int'(level), 5);
      repeat (3) step();
    end
    wait_drain(100, "pushpop");
    repeat (4) step();
    chk("pp_level_post", int'(level), 0);

    busy_len = 50;
    tx_en = 1'b0;
    push(8'hD0, 1'b1);
    for (int i = 1; i < 4; i++) push(8'hD0 + 8'(i), 1'b0);
    tx_en = 1'b1;
    wait_drain(20, "soft");
    repeat (5) step();
    chk("soft_level_pre", int'(level), 3);
    chk("soft_ovf_pre", int'(ovf), 1);
    rst_soft = 1'b1;
    step();
    rst_soft = 1'b0;
    chk("soft_level", int'(level), 0);
    chk("soft_empty", int'(empty), 1);
    chk("soft_full", int'(full), 0);
    chk("soft_ovf", int'(ovf), 0);
    chk("soft_data", int'(core_data), 0);
    p = pulses;
    repeat (120) step();
    chk("soft_no_pulse", pulses, p);
    busy_len = 0;

    tx_en = 1'b0;
    for (int i = 0; i < 16; i++) push(8'h70 + 8'(i), 1'b0);
    push(8'hEE, 1'b0);
    chk("ovf2_set", int'(ovf), 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf2_cleared", int'(ovf), 0);
    chk("ovf2_level", int'(level), 16);
    rst_soft = 1'b1;
    step();
    rst_soft = 1'b0;
    chk("ovf2_soft_level", int'(level), 0);
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
